imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Host-side writer for the instruction memory write port (we/addr/wdata) of the `mem` instance used as imem.
- Receives a framed word stream over a valid/ready handshake: header, payload, checksum.
- Writes the payload into consecutive imem addresses.
- Holds the core pipeline in reset until a load completes, then releases it.
- Sits beside the CPU top, multiplexed onto the imem port while the core is held.

Parameters:
- ADDR_W, `SIZE_ADDR, imem address width (`HBIT_ADDR+1).
- DATA_W, `SIZE_DATA, stream word and imem data width (`HBIT_DATA+1).

Ports:
- iw_clk  in  1  clock.
- iw_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- iw_start  in  1  one-cycle pulse; begins a new load frame (ignored unless in IDLE or DONE).
- iw_valid  in  1  stream word valid.
- iw_data  in  DATA_W  stream word.
- ow_ready  out  1  loader accepts iw_data this cycle.
- ow_mem_we  out  1  imem write enable.
- ow_mem_addr  out  ADDR_W  imem address.
- ow_mem_wdata  out  DATA_W  imem write data.
- ow_core_rst  out  1  active-high reset to the core (drives the core's iw_rst).
- ow_busy  out  1  frame in progress (any state except IDLE and DONE).
- ow_done  out  1  last frame ended with a checksum match.
- ow_err  out  1  last frame ended with a checksum mismatch.

Behaviour:
- Reset (async, iw_rst_n=0):
  - State=IDLE.
  - ow_core_rst=1; ow_ready, ow_mem_we, ow_busy, ow_done, ow_err=0.
  - ow_mem_addr and ow_mem_wdata=0.
  - Internal base, count, ptr and sum=0.
- Handshake: a word transfers on a rising edge where iw_valid&&ow_ready. ow_ready depends only on state (no combinational path from iw_valid).
- States and transitions:
  - IDLE: ow_ready=0, ow_core_rst=1. iw_start -> HDR_ADDR; clears done/err.
  - HDR_ADDR: ow_ready=1. Transfer: base=iw_data[ADDR_W-1:0]; ptr=base; sum=iw_data -> HDR_LEN.
  - HDR_LEN: ow_ready=1. Transfer: count=iw_data; sum+=iw_data. Go to CHK if iw_data==0, else PAYLOAD.
  - PAYLOAD: ow_ready=1. Per transfer:
    - register ow_mem_we=1, ow_mem_addr=ptr, ow_mem_wdata=iw_data, so the write appears the cycle after the transfer;
    - ptr+=1, wrapping modulo 2^ADDR_W;
    - sum+=iw_data; count-=1;
    - at count==1 on transfer -> CHK.
  - CHK: ow_ready=1. Transfer: ow_done=(iw_data==sum), ow_err=~(iw_data==sum) -> DONE.
  - DONE: ow_ready=0.
    - ow_core_rst=0 if ow_done, else stays 1.
    - iw_start -> HDR_ADDR; ow_core_rst=1 the following cycle; done/err cleared.
- ow_mem_we is a one-cycle pulse per payload word; 0 in all other cycles. Back-to-back transfers give back-to-back writes.
- sum is DATA_W wide, modulo 2^DATA_W; it covers the address word, the length word and all payload words.
- Payload length is DATA_W bits. A count exceeding the address space wraps ptr and overwrites earlier words (permitted, not flagged).
- iw_valid low stalls any receiving state indefinitely; no timeout.
- iw_start while busy is ignored.
- Reset mid-frame aborts immediately: no further writes, ow_core_rst=1. Words already written remain in imem.
- ow_busy = state in {HDR_ADDR, HDR_LEN, PAYLOAD, CHK}.

Decomposition:
- Add to sizes.vh: state encoding macros (SIZE_LDST=3; LDST_IDLE, LDST_HDRA, LDST_HDRL, LDST_PAY, LDST_CHK, LDST_DONE).
- Frame constants: header word count 2, trailer word count 1.
- One natural sub-module: imem_loader_ckacc, the checksum accumulator (clear/add/compare).
- The imem port mux (loader vs stg1ia) lives in the top, selected by ow_core_rst.

Test Plan:
- Reset then start; frame {0x10, 3, 0xA, 0xB, 0xC, chk=0x10+3+0xA+0xB+0xC} with continuous valid -> writes at addr 0x10/0x11/0x12 = 0xA/0xB/0xC on consecutive cycles; ow_done=1; ow_core_rst drops to 0 the cycle after DONE is entered.
- Same frame with chk wrong by 1 -> same three writes, ow_err=1, ow_done=0, ow_core_rst stays 1.
- Length 0 frame {0x5, 0, 0x5} -> no ow_mem_we pulse, ow_done=1.
- Base=2^ADDR_W-1, length 2 -> writes at addresses max then 0 (wrap).
- Random iw_valid gaps (about 50% duty) during payload -> writes occur only on transfer cycles, with correct addresses and no duplicates; iw_start pulsed mid-frame is ignored.
- Assert iw_rst_n low after the 2nd payload word of a 4-word frame -> outputs immediately at reset values, no further writes, ow_core_rst=1; a new start-and-frame then completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the imem loader: default widths, frame constants,
// loader state encoding and a state classification helper.
package imem_loader_pkg;

    localparam int unsigned LOADER_ADDR_W = 10;
    localparam int unsigned LOADER_DATA_W = 32;

    // Frame layout: address word + length word, then payload, then checksum.
    localparam int unsigned HDR_WORDS = 2;
    localparam int unsigned TRL_WORDS = 1;

    localparam int unsigned SIZE_LDST = 3;

    typedef enum logic [SIZE_LDST-1:0] {
        LDST_IDLE = 3'd0,
        LDST_HDRA = 3'd1,
        LDST_HDRL = 3'd2,
        LDST_PAY  = 3'd3,
        LDST_CHK  = 3'd4,
        LDST_DONE = 3'd5
    } ldst_e;

    // States in which the loader accepts stream words (also the busy states).
    function automatic logic ldst_receiving(input ldst_e s);
        return (s == LDST_HDRA) || (s == LDST_HDRL) ||
               (s == LDST_PAY)  || (s == LDST_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_ckacc.sv
// Checksum accumulator for the imem loader.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : sum <= data (first word of a frame)
//   add        : sum <= sum + data, modulo 2^DATA_W
//   data       : word to load/add, also the value compared against sum
//   sum        : running checksum (registered)
//   match_c    : combinational data == sum
module imem_loader_ckacc
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = LOADER_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              add,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum,
    output logic              match_c
);

    // Running sum; load takes priority so a new frame restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (load) begin
            sum <= data;
        end else if (add) begin
            sum <= sum + data;
        end
    end

    assign match_c = (data == sum);

endmodule

// File: rtl/imem_loader.sv
// Host-side instruction memory loader. Accepts a framed stream
// {base address, length, payload..., checksum} over valid/ready, writes the
// payload into consecutive imem addresses and holds the core in reset until
// a frame completes with a matching checksum.
// Ports:
//   iw_clk, iw_rst_n          : clock, async active-low reset
//   iw_start                  : pulse, begins a frame from IDLE or DONE
//   iw_valid, iw_data         : stream input; ow_ready accepts it
//   ow_mem_we/addr/wdata      : imem write port (one pulse per payload word)
//   ow_core_rst               : active-high core reset
//   ow_busy, ow_done, ow_err  : frame in progress / last result
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = LOADER_ADDR_W,
    parameter int unsigned DATA_W = LOADER_DATA_W
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_start,
    input  logic              iw_valid,
    input  logic [DATA_W-1:0] iw_data,
    output logic              ow_ready,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              ow_core_rst,
    output logic              ow_busy,
    output logic              ow_done,
    output logic              ow_err
);

    ldst_e             state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [DATA_W-1:0] count, count_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic              sum_load, sum_add;
    logic              sum_match_c;
    logic [DATA_W-1:0] sum;

    // ready is registered from state, so a transfer never depends on valid combinationally.
    assign xfer = iw_valid && ready_q;

    imem_loader_ckacc #(
        .DATA_W (DATA_W)
    ) u_ckacc (
        .clk     (iw_clk),
        .rst_n   (iw_rst_n),
        .load    (sum_load),
        .add     (sum_add),
        .data    (iw_data),
        .sum     (sum),
        .match_c (sum_match_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        count_d    = count;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        core_rst_d = 1'b1;
        done_d     = done_q;
        err_d      = err_q;
        sum_load   = 1'b0;
        sum_add    = 1'b0;

        case (state)
            LDST_IDLE: begin
                if (iw_start) begin
                    state_d = LDST_HDRA;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LDST_HDRA: begin
                if (xfer) begin
                    ptr_d    = iw_data[ADDR_W-1:0];
                    sum_load = 1'b1;
                    state_d  = LDST_HDRL;
                end
            end
            LDST_HDRL: begin
                if (xfer) begin
                    count_d = iw_data;
                    sum_add = 1'b1;
                    state_d = (iw_data == '0) ? LDST_CHK : LDST_PAY;
                end
            end
            LDST_PAY: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = ptr;
                    wdata_d = iw_data;
                    ptr_d   = ptr + ADDR_W'(1);
                    count_d = count - DATA_W'(1);
                    sum_add = 1'b1;
                    if (count == DATA_W'(1)) begin
                        state_d = LDST_CHK;
                    end
                end
            end
            LDST_CHK: begin
                if (xfer) begin
                    done_d  = sum_match_c;
                    err_d   = ~sum_match_c;
                    state_d = LDST_DONE;
                end
            end
            LDST_DONE: begin
                if (iw_start) begin
                    state_d = LDST_HDRA;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    // Core runs only after a good frame; a bad one keeps it held.
                    core_rst_d = ~done_q;
                end
            end
            default: begin
                state_d = LDST_IDLE;
            end
        endcase

        ready_d = ldst_receiving(state_d);
        busy_d  = ldst_receiving(state_d);
    end

    // State and output registers.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state      <= LDST_IDLE;
            ptr        <= '0;
            count      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            count      <= count_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ow_ready     = ready_q;
    assign ow_busy      = busy_q;
    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = wdata_q;
    assign ow_core_rst  = core_rst_q;
    assign ow_done      = done_q;
    assign ow_err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built in the bench, the
// expected imem contents and checksum verdict come from a frame-level model.
module tb_imem_loader;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .iw_clk       (clk),
        .iw_rst_n     (rst_n),
        .iw_start     (start),
        .iw_valid     (valid),
        .iw_data      (data),
        .ow_ready     (ready),
        .ow_mem_we    (mem_we),
        .ow_mem_addr  (mem_addr),
        .ow_mem_wdata (mem_wdata),
        .ow_core_rst  (core_rst),
        .ow_busy      (busy),
        .ow_done      (done),
        .ow_err       (err)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Captured imem writes, sampled mid-cycle.
    logic [AW-1:0] cap_addr[$];
    logic [DW-1:0] cap_data[$];
    longint        cap_cyc[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
            cap_cyc.push_back(cyc);
        end
    end

    // Frame model state.
    logic [DW-1:0] pay[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    function automatic logic [DW-1:0] frame_sum(input logic [DW-1:0] base_word);
        logic [DW-1:0] s;
        s = base_word + DW'(pay.size());
        foreach (pay[i]) s = s + pay[i];
        return s;
    endfunction

    function automatic void build_expected(input logic [DW-1:0] base_word);
        exp_addr.delete();
        exp_data.delete();
        foreach (pay[i]) begin
            exp_addr.push_back(AW'((int'(base_word) + i) % (1 << AW)));
            exp_data.push_back(pay[i]);
        end
    endfunction

    function automatic void clear_capture();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endfunction

    // -1 when captured writes equal expected, -2 on count mismatch, else first bad index.
    function automatic int first_bad_write();
        if (cap_addr.size() != exp_addr.size()) return -2;
        foreach (cap_addr[i])
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) return i;
        return -1;
    endfunction

    function automatic bit writes_consecutive();
        for (int i = 1; i < cap_cyc.size(); i++)
            if (cap_cyc[i] != cap_cyc[i-1] + 1) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one word until accepted; returns on a negedge. Optional idle gaps
    // and an optional start pulse alongside the word.
    task automatic drive_word(input logic [DW-1:0] w, input int gap_pct, input bit pulse_mid);
        logic rdy;
        int   n;
        if (gap_pct > 0) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 99) >= gap_pct) break;
                valid = 1'b0;
                data  = DW'($urandom);
                @(negedge clk);
            end
        end
        valid = 1'b1;
        data  = w;
        if (pulse_mid) start = 1'b1;
        n = 0;
        forever begin
            rdy = ready;
            @(posedge clk);
            if (rdy === 1'b1) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout word=%h ready=%b want=1", w, ready);
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_frame(input logic [DW-1:0] base_word, input logic [DW-1:0] chk,
                               input int gap_pct, input bit mid_start);
        pulse_start();
        drive_word(base_word, gap_pct, 1'b0);
        drive_word(DW'(pay.size()), gap_pct, 1'b0);
        foreach (pay[i]) drive_word(pay[i], gap_pct, mid_start && (i == 1));
        drive_word(chk, gap_pct, 1'b0);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, mem_we, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {ready, mem_we, busy, done, err});
        end
        checks++;
        if (core_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_core_rst got=%b want=1", core_rst);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_mem_bus got=%h/%h want=0/0", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int bad;
        pay = '{16'h000A, 16'h000B, 16'h000C};
        build_expected(16'h0010);
        clear_capture();
        drive_frame(16'h0010, 16'h0034, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_status got done=%b err=%b busy=%b ready=%b want 1 0 0 0",
                     done, err, busy, ready);
        end
        checks++;
        if (core_rst !== 1'b1) begin
            failures++;
            $display("FAIL basic_core_rst_first_done_cycle got=%b want=1", core_rst);
        end
        checks++;
        bad = first_bad_write();
        if (bad != -1) begin
            failures++;
            $display("FAIL basic_writes idx=%0d got_n=%0d want_n=%0d", bad, cap_addr.size(), exp_addr.size());
        end
        checks++;
        if (!writes_consecutive()) begin
            failures++;
            $display("FAIL basic_write_timing got=gapped want=consecutive");
        end
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b0) begin
            failures++;
            $display("FAIL basic_core_release got=%b want=0", core_rst);
        end
    endtask

    task automatic test_bad_chk();
        int bad;
        pay = '{16'h000A, 16'h000B, 16'h000C};
        build_expected(16'h0010);
        clear_capture();
        drive_frame(16'h0010, 16'h0035, 0, 1'b0);
        checks++;
        if (done !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL badchk_status got done=%b err=%b want done=0 err=1", done, err);
        end
        checks++;
        bad = first_bad_write();
        if (bad != -1) begin
            failures++;
            $display("FAIL badchk_writes idx=%0d got_n=%0d want_n=%0d", bad, cap_addr.size(), exp_addr.size());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (core_rst !== 1'b1) begin
            failures++;
            $display("FAIL badchk_core_held got=%b want=1", core_rst);
        end
    endtask

    task automatic test_len0();
        pay.delete();
        clear_capture();
        drive_frame(16'h0005, 16'h0005, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL len0_status got done=%b err=%b want done=1 err=0", done, err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cap_addr.size() != 0) begin
            failures++;
            $display("FAIL len0_no_write got_writes=%0d want=0", cap_addr.size());
        end
    endtask

    task automatic test_wrap();
        pay = '{DW'($urandom), DW'($urandom)};
        clear_capture();
        drive_frame(16'h00FF, frame_sum(16'h00FF), 0, 1'b0);
        checks++;
        if (cap_addr.size() != 2) begin
            failures++;
            $display("FAIL wrap_count got=%0d want=2", cap_addr.size());
        end else if (cap_addr[0] !== 8'hFF || cap_addr[1] !== 8'h00 ||
                     cap_data[0] !== pay[0] || cap_data[1] !== pay[1]) begin
            failures++;
            $display("FAIL wrap_writes got=%h:%h %h:%h want=ff:%h 00:%h",
                     cap_addr[0], cap_data[0], cap_addr[1], cap_data[1], pay[0], pay[1]);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done got=%b want=1", done);
        end
    endtask

    task automatic test_random_gaps();
        logic [DW-1:0] base_word, chk;
        bit            good;
        int            bad;
        for (int f = 0; f < 8; f++) begin
            base_word = DW'($urandom);
            pay.delete();
            for (int i = 0; i < int'($urandom_range(2, 6)); i++) pay.push_back(DW'($urandom));
            good = ($urandom_range(0, 1) == 1);
            chk  = frame_sum(base_word) + (good ? DW'(0) : DW'($urandom_range(1, 255)));
            build_expected(base_word);
            clear_capture();
            drive_frame(base_word, chk, 50, 1'b1);
            checks++;
            if (done !== good || err !== !good) begin
                failures++;
                $display("FAIL rand_status frame=%0d got done=%b err=%b want done=%b err=%b",
                         f, done, err, good, !good);
            end
            checks++;
            bad = first_bad_write();
            if (bad != -1) begin
                failures++;
                $display("FAIL rand_writes frame=%0d idx=%0d got_n=%0d want_n=%0d",
                         f, bad, cap_addr.size(), exp_addr.size());
            end
            @(negedge clk);
            checks++;
            if (core_rst !== !good) begin
                failures++;
                $display("FAIL rand_core_rst frame=%0d got=%b want=%b", f, core_rst, !good);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        pay = '{16'h1111, 16'h2222};
        drive_frame(16'h0030, frame_sum(16'h0030), 0, 1'b0);
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b0) begin
            failures++;
            $display("FAIL b2b_released got=%b want=0", core_rst);
        end
        pay = '{16'h3333, 16'h4444, 16'h5555};
        build_expected(16'h0032);
        clear_capture();
        pulse_start();
        checks++;
        if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got rst=%b done=%b err=%b busy=%b want 1 0 0 1",
                     core_rst, done, err, busy);
        end
        drive_word(16'h0032, 0, 1'b0);
        drive_word(DW'(3), 0, 1'b0);
        foreach (pay[i]) drive_word(pay[i], 0, 1'b0);
        drive_word(frame_sum(16'h0032), 0, 1'b0);
        valid = 1'b0;
        checks++;
        bad = first_bad_write();
        if (bad != -1 || done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_frame idx=%0d done=%b want idx=-1 done=1", bad, done);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        pay = '{DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
        build_expected(16'h0040);
        clear_capture();
        pulse_start();
        drive_word(16'h0040, 0, 1'b0);
        drive_word(DW'(4), 0, 1'b0);
        drive_word(pay[0], 0, 1'b0);
        drive_word(pay[1], 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, mem_we, busy, done, err} !== 5'b0 || core_rst !== 1'b1 ||
            mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got rdy=%b we=%b busy=%b done=%b err=%b rst=%b addr=%h wd=%h want reset values",
                     ready, mem_we, busy, done, err, core_rst, mem_addr, mem_wdata);
        end
        valid = 1'b1;
        data  = pay[2];
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        checks++;
        if (cap_addr.size() != 2 || cap_addr[0] !== exp_addr[0] || cap_addr[1] !== exp_addr[1] ||
            cap_data[0] !== exp_data[0] || cap_data[1] !== exp_data[1]) begin
            failures++;
            $display("FAIL midrst_writes got_n=%0d want_n=2", cap_addr.size());
        end
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle got rst=%b busy=%b want rst=1 busy=0", core_rst, busy);
        end
        pay = '{DW'($urandom), DW'($urandom), DW'($urandom)};
        build_expected(16'h00A0);
        clear_capture();
        drive_frame(16'h00A0, frame_sum(16'h00A0), 0, 1'b0);
        checks++;
        bad = first_bad_write();
        if (bad != -1 || done !== 1'b1) begin
            failures++;
            $display("FAIL midrst_recover idx=%0d done=%b want idx=-1 done=1", bad, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_len0();
        test_wrap();
        test_random_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
